// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and bit-timing helpers
// used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // Clocks per bit time (integer divide).
    function automatic int unsigned uart_period(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Mid-bit sample offset within one bit time.
    function automatic int unsigned uart_half(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
        return uart_period(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle
// (high) line level so no false start bit is seen out of reset.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop recovery, one-entry valid/ready holding
// register, framing-error and overrun pulses. Optional UART_RX_MAJORITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned PERIOD = uart_period(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF   = uart_half(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW     = $clog2(PERIOD);
    localparam int unsigned BCW    = $clog2(DATA_BITS) + 1;

    logic                 rx_s;
    logic                 sample_pt;
    logic                 bit_val;
    logic                 deliver;

    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        clk_count_q, clk_count_d;
    logic [BCW-1:0]       bit_count_q, bit_count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds rx_s at HALF and hist_q[1] at HALF-1 when the decision
    // is taken one cycle late at HALF+1.
    logic [1:0] hist_q, hist_d;

    always_comb hist_d = {hist_q[0], rx_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= '1;
        else        hist_q <= hist_d;
    end

    assign sample_pt = (clk_count_q == CW'(HALF + 1));
    assign bit_val   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample_pt = (clk_count_q == CW'(HALF));
    assign bit_val   = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        clk_count_d = (clk_count_q == CW'(PERIOD - 1)) ? '0 : clk_count_q + 1'b1;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                clk_count_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (sample_pt) begin
                    if (!bit_val) begin
                        state_d     = DATA;
                        bit_count_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_count_q == BCW'(DATA_BITS - 1)) begin
                        state_d     = STOP;
                        bit_count_d = '0;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_pt) begin
                    if (!bit_val) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end else if (bit_count_q == BCW'(STOP_BITS - 1)) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                clk_count_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a same-cycle accept frees the slot for a new byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && data_ready) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_count_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
